// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of three memory requesters per cycle, registers the memory
// command and routes read data back to its issuer. Define MEM_ARB_AGING_EN for anti-starvation aging.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 136,
  parameter int AGE_MAX = 15
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          fpu_req,
  input  logic [AW-1:0] fpu_addr,
  output logic          fpu_ack,
  output logic          fpu_rvalid,
  output logic [DW-1:0] fpu_rdata,
  input  logic          tx_req,
  input  logic [AW-1:0] tx_addr,
  output logic          tx_ack,
  output logic          tx_rvalid,
  output logic [DW-1:0] tx_rdata,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FPU  = 2'd1,
    OWN_TX   = 2'd2
  } owner_e;

  logic          grant_wr_s;
  logic          grant_fpu_s;
  logic          grant_tx_s;
  logic          aged_wr_s;
  logic          aged_fpu_s;
  logic          aged_tx_s;
  logic          mem_wen_r;
  logic          mem_ren_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  owner_e        own0_r;
  owner_e        own1_r;
  owner_e        own0_next_s;

`ifdef MEM_ARB_AGING_EN
  localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age_wr_r;
  logic [AGE_W-1:0] age_fpu_r;
  logic [AGE_W-1:0] age_tx_r;

  function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] cnt,
                                                input logic req, input logic ack);
    logic [AGE_W-1:0] nxt;
    if (!req || ack) begin
      nxt = {AGE_W{1'b0}};
    end else if (cnt == AGE_LIM) begin
      nxt = cnt;
    end else begin
      nxt = cnt + AGE_W'(1'b1);
    end
    return nxt;
  endfunction

  assign aged_wr_s  = wr_req  & (age_wr_r  == AGE_LIM);
  assign aged_fpu_s = fpu_req & (age_fpu_r == AGE_LIM);
  assign aged_tx_s  = tx_req  & (age_tx_r  == AGE_LIM);

  // Per-requester waiting time; an ack or a dropped request restarts the count.
  always_ff @(posedge clk) begin
    if (resetn) begin
      age_wr_r  <= {AGE_W{1'b0}};
      age_fpu_r <= {AGE_W{1'b0}};
      age_tx_r  <= {AGE_W{1'b0}};
    end else begin
      age_wr_r  <= age_next(age_wr_r,  wr_req,  grant_wr_s);
      age_fpu_r <= age_next(age_fpu_r, fpu_req, grant_fpu_s);
      age_tx_r  <= age_next(age_tx_r,  tx_req,  grant_tx_s);
    end
  end
`else
  assign aged_wr_s  = 1'b0;
  assign aged_fpu_s = 1'b0;
  assign aged_tx_s  = 1'b0;
`endif

  // Grant selection: aged requesters first, then fixed wr > fpu > tx; nothing during reset.
  always_comb begin
    grant_wr_s  = 1'b0;
    grant_fpu_s = 1'b0;
    grant_tx_s  = 1'b0;
    if (resetn) begin
      grant_wr_s = 1'b0;
    end else if (aged_wr_s) begin
      grant_wr_s = 1'b1;
    end else if (aged_fpu_s) begin
      grant_fpu_s = 1'b1;
    end else if (aged_tx_s) begin
      grant_tx_s = 1'b1;
    end else if (wr_req) begin
      grant_wr_s = 1'b1;
    end else if (fpu_req) begin
      grant_fpu_s = 1'b1;
    end else if (tx_req) begin
      grant_tx_s = 1'b1;
    end else begin
      grant_wr_s = 1'b0;
    end
  end

  assign wr_ack  = grant_wr_s;
  assign fpu_ack = grant_fpu_s;
  assign tx_ack  = grant_tx_s;

  // Memory command register; address and write data hold when idle.
  always_ff @(posedge clk) begin
    if (resetn) begin
      mem_wen_r   <= 1'b0;
      mem_ren_r   <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else begin
      mem_wen_r <= grant_wr_s;
      mem_ren_r <= grant_fpu_s | grant_tx_s;
      if (grant_wr_s) begin
        mem_addr_r  <= wr_addr;
        mem_wdata_r <= wr_data;
      end else if (grant_fpu_s) begin
        mem_addr_r <= fpu_addr;
      end else if (grant_tx_s) begin
        mem_addr_r <= tx_addr;
      end
    end
  end

  assign mem_wen   = mem_wen_r;
  assign mem_ren   = mem_ren_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  // Owner tag entering the return pipeline this cycle.
  always_comb begin
    own0_next_s = OWN_NONE;
    if (grant_fpu_s) begin
      own0_next_s = OWN_FPU;
    end else if (grant_tx_s) begin
      own0_next_s = OWN_TX;
    end else begin
      own0_next_s = OWN_NONE;
    end
  end

  // Two-stage owner pipeline aligned with the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (resetn) begin
      own0_r <= OWN_NONE;
      own1_r <= OWN_NONE;
    end else begin
      own0_r <= own0_next_s;
      own1_r <= own0_r;
    end
  end

  // Returns still in the pipeline while reset is asserted are discarded.
  assign fpu_rvalid = ~resetn & (own1_r == OWN_FPU);
  assign tx_rvalid  = ~resetn & (own1_r == OWN_TX);
  assign fpu_rdata  = mem_rdata;
  assign tx_rdata   = mem_rdata;

  assign busy = wr_req | fpu_req | tx_req |
                (~resetn & ((own0_r != OWN_NONE) | (own1_r != OWN_NONE)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grants,
// memory commands and read returns; a separate monitor compares returns and commands.
module tb_mem_arbiter;
  localparam int AW      = 8;
  localparam int DW      = 136;
  localparam int AGE_MAX = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_req, fpu_req, tx_req;
  logic [AW-1:0] wr_addr, fpu_addr, tx_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, fpu_ack, tx_ack;
  logic          fpu_rvalid, tx_rvalid;
  logic [DW-1:0] fpu_rdata, tx_rdata;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fpu_req(fpu_req), .fpu_addr(fpu_addr), .fpu_ack(fpu_ack),
    .fpu_rvalid(fpu_rvalid), .fpu_rdata(fpu_rdata),
    .tx_req(tx_req), .tx_addr(tx_addr), .tx_ack(tx_ack),
    .tx_rvalid(tx_rvalid), .tx_rdata(tx_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory instance stand-in: registered read, one cycle after mem_ren.
  logic [DW-1:0] mem_arr [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_arr[mem_addr];
    if (mem_wen) mem_arr[mem_addr] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int owner; logic [DW-1:0] data; } ret_t;
  typedef struct { int due; logic wen; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
  ret_t ret_q[$];
  cmd_t cmd_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  int waited [3] = '{0, 0, 0};
  int gcyc [3]   = '{0, 0, 0};
  int gnt = -1;

  // Stimulus state applied to the DUT each cycle
  logic          rst_v = 1'b1;
  logic          req_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [AW-1:0] addr_v [3] = '{8'd0, 8'd0, 8'd0};
  logic [DW-1:0] data_v = '0;

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic apply();
    resetn   = rst_v;
    wr_req   = req_v[0];
    fpu_req  = req_v[1];
    tx_req   = req_v[2];
    wr_addr  = addr_v[0];
    fpu_addr = addr_v[1];
    tx_addr  = addr_v[2];
    wr_data  = data_v;
  endtask

  task automatic model_cycle();
    logic r [3];
    int g;
    logic [AW-1:0] a;
    r[0] = wr_req; r[1] = fpu_req; r[2] = tx_req;
    g = -1;
    if (resetn) begin
      for (int i = 0; i < 3; i++) waited[i] = 0;
    end else begin
`ifdef MEM_ARB_AGING_EN
      for (int i = 0; i < 3; i++) if (g < 0 && r[i] && waited[i] >= AGE_MAX) g = i;
`endif
      for (int i = 0; i < 3; i++) if (g < 0 && r[i]) g = i;
      for (int i = 0; i < 3; i++) waited[i] = (r[i] && i != g) ? waited[i] + 1 : 0;
    end
    chk("wr_ack",  DW'(wr_ack),  DW'(g == 0));
    chk("fpu_ack", DW'(fpu_ack), DW'(g == 1));
    chk("tx_ack",  DW'(tx_ack),  DW'(g == 2));
    gnt = g;
    if (g >= 0) gcyc[g] = cyc;
    if (g == 0) begin
      ref_mem[wr_addr] = wr_data;
      cmd_q.push_back('{cyc + 1, 1'b1, wr_addr, wr_data});
    end else if (g > 0) begin
      a = (g == 1) ? fpu_addr : tx_addr;
      cmd_q.push_back('{cyc + 1, 1'b0, a, '0});
      ret_q.push_back('{cyc + 2, g, ref_mem[a]});
    end
  endtask

  task automatic step();
    apply();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks read returns, memory commands and busy against scoreboard queues.
  always @(negedge clk) begin
    int own;
    logic inflight;
    inflight = 1'b0;
    foreach (ret_q[i]) if (ret_q[i].due <= cyc + 1) inflight = 1'b1;
    chk("busy", DW'(busy), DW'(wr_req | fpu_req | tx_req | (!resetn & inflight)));
    if (resetn) ret_q.delete();
    own = 0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) own = ret_q[0].owner;
    chk("fpu_rvalid", DW'(fpu_rvalid), DW'(own == 1));
    chk("tx_rvalid",  DW'(tx_rvalid),  DW'(own == 2));
    if (own == 1) chk("fpu_rdata", fpu_rdata, ret_q[0].data);
    if (own == 2) chk("tx_rdata",  tx_rdata,  ret_q[0].data);
    if (own != 0) void'(ret_q.pop_front());
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      chk("mem_wen",  DW'(mem_wen), DW'(cmd_q[0].wen));
      chk("mem_ren",  DW'(mem_ren), DW'(!cmd_q[0].wen));
      chk("mem_addr", DW'(mem_addr), DW'(cmd_q[0].addr));
      if (cmd_q[0].wen) chk("mem_wdata", mem_wdata, cmd_q[0].wdata);
      void'(cmd_q.pop_front());
    end else begin
      chk("mem_wen_idle", DW'(mem_wen), DW'(1'b0));
      chk("mem_ren_idle", DW'(mem_ren), DW'(1'b0));
    end
  end

  task automatic do_req(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    req_v[who] = 1'b1; addr_v[who] = a;
    if (who == 0) data_v = d;
    for (int k = 0; k < 50 && !got; k++) begin
      step();
      if (gnt == who) got = 1'b1;
    end
    chk("req_granted", DW'(got), DW'(1'b1));
    req_v[who] = 1'b0;
  endtask

  initial begin
    int txg;
    logic got;
    apply();
    // Reset with every request raised
    req_v = '{1'b1, 1'b1, 1'b1};
    step();
    step();
    rst_v = 1'b0;
    req_v = '{1'b0, 1'b0, 1'b0};
    chk("rst_mem_addr",  DW'(mem_addr), DW'(0));
    chk("rst_mem_wdata", mem_wdata, DW'(0));
    step();

    // Single FPU read of a known word
    do_req(0, 8'h12, DW'(16'hABCD));
    step(); step();
    do_req(1, 8'h12, '0);
    step(); step(); step();

    // Three simultaneous requests resolve wr, fpu, tx on consecutive cycles
    req_v = '{1'b1, 1'b1, 1'b1};
    addr_v = '{8'h20, 8'h21, 8'h12};
    data_v = rand_data();
    for (int k = 0; k < 10; k++) begin
      step();
      if (gnt >= 0) req_v[gnt] = 1'b0;
    end
    chk("prio_fpu_next", DW'(gcyc[1] - gcyc[0]), DW'(1));
    chk("prio_tx_after", DW'(gcyc[2] - gcyc[0]), DW'(2));

    // Read-after-write through the tx path
    req_v = '{1'b1, 1'b0, 1'b1};
    addr_v = '{8'h03, 8'h00, 8'h03};
    data_v = DW'(8'h55);
    for (int k = 0; k < 6; k++) begin
      step();
      if (gnt >= 0) req_v[gnt] = 1'b0;
    end

    // Reset one cycle after an fpu grant drops the return
    do_req(1, 8'h12, '0);
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    step(); step(); step();

    // Starvation behaviour of tx under constant wr and fpu load
    req_v = '{1'b1, 1'b1, 1'b0};
    addr_v = '{8'h05, 8'h06, 8'h07};
    step(); step();
    req_v[2] = 1'b1;
    txg = 0;
    got = 1'b0;
`ifdef MEM_ARB_AGING_EN
    for (int k = 0; k <= AGE_MAX + 3 && !got; k++) begin
      step();
      if (gnt == 2) begin got = 1'b1; req_v[2] = 1'b0; end
      else if (gnt >= 0) begin addr_v[gnt] = AW'($urandom_range(15, 0)); data_v = rand_data(); end
    end
    chk("tx_aged_ack", DW'(got), DW'(1'b1));
`else
    for (int k = 0; k < 40; k++) begin
      step();
      if (gnt == 2) txg++;
      else if (gnt >= 0) begin addr_v[gnt] = AW'($urandom_range(15, 0)); data_v = rand_data(); end
    end
    chk("tx_starved", DW'(txg), DW'(0));
`endif
    req_v = '{1'b0, 1'b0, 1'b0};
    step(); step(); step();

    // Randomized traffic with occasional withdrawals and resets
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (req_v[i] && gnt == i) begin
          if ($urandom_range(1, 0) == 0) req_v[i] = 1'b0;
          addr_v[i] = AW'($urandom_range(15, 0));
          if (i == 0) data_v = rand_data();
        end else if (req_v[i]) begin
          if ($urandom_range(15, 0) == 0) req_v[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req_v[i] = 1'b1;
          addr_v[i] = AW'($urandom_range(15, 0));
          if (i == 0) data_v = rand_data();
        end
      end
      rst_v = ($urandom_range(199, 0) == 0);
      step();
    end

    rst_v = 1'b0;
    req_v = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) step();
    chk("drain_empty", DW'(ret_q.size() + cmd_q.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter and read-return router for the coprocessor main memory. It sits between three requesters and one memory instance: the comm receive path (writes), the FPU operand fetch (reads) and the comm transmit path (reads). Each cycle it grants at most one request, issues a registered memory command, and steers returning read data to the requester that issued the read. Fixed priority is the default; an optional aging scheme prevents starvation.

## Interface
- AW, 8, memory address width
- DW, 136, memory data width (matches tx_data)
- AGE_MAX, 15, aging threshold in cycles (used only with MEM_ARB_AGING_EN)

- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-high reset (1 = reset; port name kept as in the rest of the codebase)
- wr_req  in  1  receive-path write request
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_ack  out  1  write granted this cycle
- fpu_req  in  1  FPU read request
- fpu_addr  in  AW  FPU read address
- fpu_ack  out  1  FPU read granted this cycle
- fpu_rvalid  out  1  fpu_rdata valid
- fpu_rdata  out  DW  FPU read data
- tx_req  in  1  transmit read request
- tx_addr  in  AW  transmit read address
- tx_ack  out  1  transmit read granted this cycle
- tx_rvalid  out  1  tx_rdata valid
- tx_rdata  out  DW  transmit read data
- mem_wen  out  1  memory write strobe
- mem_ren  out  1  memory read strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, registered, valid 1 cycle after mem_ren
- busy  out  1  any req high or any read in flight

## Operation
- Requester handshake: hold req with stable addr/data until ack; ack is a 1-cycle, combinational pulse in the grant cycle. Keeping req high after ack requests the next access (back-to-back allowed, one per cycle).
- Default priority: wr > fpu > tx. Exactly one ack high per cycle, or none.
- Command register: on grant, mem_wen or mem_ren, mem_addr and mem_wdata are loaded and held for one cycle; with no grant both strobes are 0 and addr/wdata hold their previous values.
- Return tracking: 2-stage owner shift register (none/fpu/tx). The owner tag enters at grant; the matching rvalid is asserted when mem_rdata is valid.
- fpu_rdata and tx_rdata are both driven from mem_rdata. Only the owner's rvalid is asserted.
- Writes produce no return.
- Read-after-write to the same address in consecutive grants returns the new data; the memory orders commands and the arbiter never reorders.
- busy = wr_req | fpu_req | tx_req | any owner stage non-empty.

## Timing
- Grant at cycle T gives ack at T, mem strobe at T+1, and rvalid with data at T+2. Read latency from ack to data is fixed at 2 cycles.
- Sustained throughput is 1 access per cycle.
- Reset values: all acks 0, mem_wen 0, mem_ren 0, mem_addr 0, mem_wdata 0, both rvalids 0, owner stages empty, age counters 0.
- busy follows its combinational definition during reset, with empty owner stages.
- Reset mid-operation: in-flight reads are discarded and no rvalid is asserted for them. A memory command registered in the reset cycle is not issued.
- Simultaneous requests resolve by priority (or aging); losers keep waiting without an ack.
- A req deasserted before its ack is a withdrawn request; no side effects.

## Configuration
- MEM_ARB_AGING_EN defined:
  - Each requester has a saturating counter of width ceil(log2(AGE_MAX+1)).
  - The counter increments each cycle its req is high and not acked, and clears on ack or when req is low.
  - Any requester whose counter equals AGE_MAX overrides default priority. If several are aged, they resolve among themselves by wr > fpu > tx.
  - Bound: a requester is acked within AGE_MAX+3 cycles of raising req.
- Undefined: pure fixed priority, no counters; tx may starve indefinitely.

## Test plan
- Reset check: resetn high 2 cycles with all reqs 1 -> no acks, no strobes, no rvalid; all registered outputs 0.
- Single FPU read, fpu_addr=0x12 with mem holding 0xABCD at 0x12 -> fpu_ack at T, mem_ren=1 with mem_addr=0x12 at T+1, fpu_rvalid=1 and fpu_rdata=0xABCD at T+2; tx_rvalid stays 0.
- All three reqs asserted at T -> wr_ack at T, fpu_ack at T+1, tx_ack at T+2; tx_rvalid at T+4.
- Write 0x55 to addr 3, then an immediate tx read of addr 3 -> tx_rdata=0x55.
- Reset mid-operation: resetn pulses at T+1 after an fpu grant at T -> no fpu_rvalid at T+2.
- With MEM_ARB_AGING_EN and AGE_MAX=4: wr_req and fpu_req held high continuously, tx_req raised at T -> tx_ack no later than T+7. Without the macro, tx_ack never occurs.
